// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared encodings for the LED pattern sequencer
// (mode, colour and ping-pong direction constants).
package led_seq_pkg;

   localparam logic [1:0] MODE_ROT_L    = 2'd0;
   localparam logic [1:0] MODE_ROT_R    = 2'd1;
   localparam logic [1:0] MODE_PINGPONG = 2'd2;
   localparam logic [1:0] MODE_FLASH    = 2'd3;

   localparam logic [1:0] COLOR_R = 2'd0;
   localparam logic [1:0] COLOR_G = 2'd1;
   localparam logic [1:0] COLOR_B = 2'd2;
   localparam logic [1:0] COLOR_W = 2'd3;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// led_pattern_sequencer_if: control inputs and LED outputs of the sequencer.
// master = board/controller side, slave = sequencer side.
interface led_pattern_sequencer_if #(parameter int NB_LEDS = 4);

   logic               i_enable;
   logic [1:0]         i_mode;
   logic [1:0]         i_speed;
   logic [1:0]         i_color;
   logic [NB_LEDS-1:0] o_led;
   logic [NB_LEDS-1:0] o_led_r;
   logic [NB_LEDS-1:0] o_led_g;
   logic [NB_LEDS-1:0] o_led_b;
   logic               o_tick;

   modport master (output i_enable, i_mode, i_speed, i_color,
                   input  o_led, o_led_r, o_led_g, o_led_b, o_tick);
   modport slave  (input  i_enable, i_mode, i_speed, i_color,
                   output o_led, o_led_r, o_led_g, o_led_b, o_tick);

endinterface

// File: rtl/led_pattern_sequencer_tick_gen.sv
// tick_gen: step-rate counter with a 4-way period select. The '>=' compare
// guarantees a wrap when the period shrinks below the current count.
module tick_gen #(
   parameter int NB_COUNTER = 32,
   parameter     LIMIT_0    = 2**23,
   parameter     LIMIT_1    = 2**24,
   parameter     LIMIT_2    = 2**25,
   parameter     LIMIT_3    = 2**26
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       en_i,
   input  logic       clr_i,
   input  logic [1:0] speed_i,
   output logic       wrap_o
);

   localparam logic [NB_COUNTER-1:0] TH_0 = NB_COUNTER'(LIMIT_0 - 1);
   localparam logic [NB_COUNTER-1:0] TH_1 = NB_COUNTER'(LIMIT_1 - 1);
   localparam logic [NB_COUNTER-1:0] TH_2 = NB_COUNTER'(LIMIT_2 - 1);
   localparam logic [NB_COUNTER-1:0] TH_3 = NB_COUNTER'(LIMIT_3 - 1);

   logic [NB_COUNTER-1:0] cnt_q, cnt_d, th;
   logic                  at_lim;

   // Period select, compare and next count; clear overrides enable.
   always_comb begin
      case (speed_i)
         2'd0:    th = TH_0;
         2'd1:    th = TH_1;
         2'd2:    th = TH_2;
         default: th = TH_3;
      endcase
      at_lim = (cnt_q >= th);
      wrap_o = en_i & ~clr_i & at_lim;
      cnt_d  = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = at_lim ? '0 : cnt_q + 1'b1;
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: tick-driven NB_LEDS pattern engine (rotate left/right,
// ping-pong, flash) with an RGB colour-channel mux.
// Optional feature: `define LED_SEQ_PWM_EN dims the colour outputs with a
// free-running PWM counter; o_led is never dimmed.
module led_pattern_sequencer
   import led_seq_pkg::*;
#(
   parameter int NB_LEDS    = 4,
   parameter int NB_COUNTER = 32,
   parameter     LIMIT_0    = 2**23,
   parameter     LIMIT_1    = 2**24,
   parameter     LIMIT_2    = 2**25,
   parameter     LIMIT_3    = 2**26,
   parameter int NB_PWM     = 8,
   parameter int PWM_DUTY   = 64
) (
   input  logic                      clock,
   input  logic                      i_reset,
   led_pattern_sequencer_if.slave    bus
);

   localparam logic [NB_LEDS-1:0] PAT_INIT = NB_LEDS'(1);

   logic [NB_LEDS-1:0] pat_q, pat_d;
   logic               dir_q, dir_d;
   logic [1:0]         mode_q;
   logic               tick_q, tick_d;
   logic               mode_chg, step, dim_on;
   logic               sel_r, sel_g, sel_b;

   // A mode change clears the counter and suppresses the step that cycle.
   assign mode_chg = (bus.i_mode != mode_q);

   tick_gen #(
      .NB_COUNTER (NB_COUNTER),
      .LIMIT_0    (LIMIT_0),
      .LIMIT_1    (LIMIT_1),
      .LIMIT_2    (LIMIT_2),
      .LIMIT_3    (LIMIT_3)
   ) u_tick_gen (
      .clk_i   (clock),
      .rst_ni  (i_reset),
      .en_i    (bus.i_enable),
      .clr_i   (mode_chg),
      .speed_i (bus.i_speed),
      .wrap_o  (step)
   );

   // Pattern next state: reload on mode change, else step on counter wrap.
   always_comb begin
      pat_d  = pat_q;
      dir_d  = dir_q;
      tick_d = 1'b0;
      if (mode_chg) begin
         pat_d = (bus.i_mode == MODE_FLASH) ? '1 : PAT_INIT;
         dir_d = DIR_LEFT;
      end else if (step) begin
         tick_d = 1'b1;
         case (mode_q)
            MODE_ROT_L: pat_d = {pat_q[NB_LEDS-2:0], pat_q[NB_LEDS-1]};
            MODE_ROT_R: pat_d = {pat_q[0], pat_q[NB_LEDS-1:1]};
            MODE_PINGPONG: begin
               if (dir_q == DIR_LEFT && pat_q[NB_LEDS-1]) begin
                  dir_d = DIR_RIGHT;
                  pat_d = pat_q >> 1;
               end else if (dir_q == DIR_RIGHT && pat_q[0]) begin
                  dir_d = DIR_LEFT;
                  pat_d = pat_q << 1;
               end else begin
                  pat_d = (dir_q == DIR_LEFT) ? (pat_q << 1) : (pat_q >> 1);
               end
            end
            default: pat_d = ~pat_q;
         endcase
      end
   end

   // Pattern, direction, registered mode and tick pulse.
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         pat_q  <= PAT_INIT;
         dir_q  <= DIR_LEFT;
         mode_q <= MODE_ROT_L;
         tick_q <= 1'b0;
      end else begin
         pat_q  <= pat_d;
         dir_q  <= dir_d;
         mode_q <= bus.i_mode;
         tick_q <= tick_d;
      end
   end

`ifdef LED_SEQ_PWM_EN
   localparam logic [NB_PWM:0] DUTY = (NB_PWM+1)'(PWM_DUTY);
   logic [NB_PWM-1:0] pwm_q;

   // Free-running PWM counter for colour dimming.
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) pwm_q <= '0;
      else          pwm_q <= pwm_q + 1'b1;
   end

   assign dim_on = ({1'b0, pwm_q} < DUTY);
`else
   logic unused_pwm_cfg;
   assign unused_pwm_cfg = ^{NB_PWM, PWM_DUTY};
   assign dim_on         = 1'b1;
`endif

   assign sel_r = dim_on & ((bus.i_color == COLOR_R) | (bus.i_color == COLOR_W));
   assign sel_g = dim_on & ((bus.i_color == COLOR_G) | (bus.i_color == COLOR_W));
   assign sel_b = dim_on & ((bus.i_color == COLOR_B) | (bus.i_color == COLOR_W));

   assign bus.o_led   = pat_q;
   assign bus.o_led_r = sel_r ? pat_q : '0;
   assign bus.o_led_g = sel_g ? pat_q : '0;
   assign bus.o_led_b = sel_b ? pat_q : '0;
   assign bus.o_tick  = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer (NB_LEDS=4, periods 4/2/8/1 clocks).
// Reference model tracks steps-since-reload and derives the pattern from it.
module tb_led_pattern_sequencer;

   logic clock   = 1'b0;
   logic i_reset = 1'b0;
   int   n_chk   = 0;
   int   n_pass  = 0;

   led_pattern_sequencer_if #(.NB_LEDS(4)) bus ();

   led_pattern_sequencer #(
      .NB_LEDS(4), .NB_COUNTER(32),
      .LIMIT_0(4), .LIMIT_1(2), .LIMIT_2(8), .LIMIT_3(1),
      .NB_PWM(8), .PWM_DUTY(64)
   ) dut (
      .clock   (clock),
      .i_reset (i_reset),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   int       lim [4] = '{4, 2, 8, 1};
   logic [1:0] m_mode;
   int       m_cnt, m_k, m_pwm;
   logic     m_tick;

   function automatic logic [3:0] pat_of(input logic [1:0] m, input int k);
      logic [3:0] r;
      int p;
      r = 4'h0;
      case (m)
         2'd0: p = k % 4;
         2'd1: p = (4 - (k % 4)) % 4;
         2'd2: begin p = k % 6; if (p >= 4) p = 6 - p; end
         default: return ((k % 2) == 0) ? 4'hF : 4'h0;
      endcase
      r[p] = 1'b1;
      return r;
   endfunction

   function automatic logic [3:0] exp_led();
      return pat_of(m_mode, m_k);
   endfunction

   function automatic logic [3:0] exp_col(input int ch);
      logic on;
      on = (int'(bus.i_color) == ch) || (bus.i_color == 2'd3);
`ifdef LED_SEQ_PWM_EN
      on = on && (m_pwm < 64);
`endif
      return on ? exp_led() : 4'h0;
   endfunction

   task automatic model_reset();
      m_mode = 2'd0; m_cnt = 0; m_k = 0; m_tick = 1'b0; m_pwm = 0;
   endtask

   // Advance one clock and the model; returns 1 time unit after the edge.
   task automatic clk_step();
      @(posedge clock);
      if (!i_reset) model_reset();
      else begin
         m_pwm = (m_pwm + 1) % 256;
         if (bus.i_mode != m_mode) begin
            m_mode = bus.i_mode; m_cnt = 0; m_k = 0; m_tick = 1'b0;
         end else if (bus.i_enable) begin
            if (m_cnt >= lim[bus.i_speed] - 1) begin
               m_cnt = 0; m_k++; m_tick = 1'b1;
            end else begin
               m_cnt++; m_tick = 1'b0;
            end
         end else m_tick = 1'b0;
      end
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      bus.i_enable = 1'b0; bus.i_mode = 2'd0; bus.i_speed = 2'd0; bus.i_color = 2'd0;
      i_reset = 1'b0;
      model_reset();
      repeat (3) clk_step();
      n_chk++; if (bus.o_led !== 4'h1) $display("FAIL reset_led got=%h exp=1", bus.o_led); else n_pass++;
      n_chk++; if (bus.o_tick !== 1'b0) $display("FAIL reset_tick got=%b exp=0", bus.o_tick); else n_pass++;
      n_chk++; if (bus.o_led_r !== 4'h1) $display("FAIL reset_r got=%h exp=1", bus.o_led_r); else n_pass++;
      n_chk++; if (bus.o_led_g !== 4'h0 || bus.o_led_b !== 4'h0)
         $display("FAIL reset_gb got=%h/%h exp=0/0", bus.o_led_g, bus.o_led_b); else n_pass++;
   endtask

   task automatic test_rot_left();
      logic [3:0] e;
      i_reset = 1'b1; bus.i_enable = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         clk_step();
         e = 4'b0001 << ((i / 4) % 4);
         n_chk++; if (bus.o_led !== e) $display("FAIL rotl_led cyc=%0d got=%h exp=%h", i, bus.o_led, e); else n_pass++;
         n_chk++; if (bus.o_tick !== ((i % 4) == 0)) $display("FAIL rotl_tick cyc=%0d got=%b", i, bus.o_tick); else n_pass++;
      end
   endtask

   task automatic test_pingpong();
      logic [3:0] seq [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
      bus.i_mode = 2'd2; bus.i_speed = 2'd3;
      for (int i = 0; i < 8; i++) begin
         clk_step();
         n_chk++; if (bus.o_led !== seq[i]) $display("FAIL pp_led i=%0d got=%h exp=%h", i, bus.o_led, seq[i]); else n_pass++;
         n_chk++; if (bus.o_tick !== (i != 0)) $display("FAIL pp_tick i=%0d got=%b", i, bus.o_tick); else n_pass++;
      end
   endtask

   task automatic test_flash();
      logic [3:0] seq [7] = '{4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0};
      logic       tk  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      bus.i_mode = 2'd3; bus.i_speed = 2'd1; bus.i_color = 2'd3;
      for (int i = 0; i < 7; i++) begin
         clk_step();
         n_chk++; if (bus.o_led !== seq[i]) $display("FAIL fl_led i=%0d got=%h exp=%h", i, bus.o_led, seq[i]); else n_pass++;
         n_chk++; if (bus.o_tick !== tk[i]) $display("FAIL fl_tick i=%0d got=%b exp=%b", i, bus.o_tick, tk[i]); else n_pass++;
         n_chk++; if (bus.o_led_r !== exp_col(0) || bus.o_led_g !== exp_col(1) || bus.o_led_b !== exp_col(2))
            $display("FAIL fl_rgb i=%0d got=%h/%h/%h exp=%h/%h/%h", i, bus.o_led_r, bus.o_led_g, bus.o_led_b,
                     exp_col(0), exp_col(1), exp_col(2)); else n_pass++;
      end
   endtask

   task automatic test_speed_hold();
      bus.i_mode = 2'd0; bus.i_speed = 2'd2; bus.i_color = 2'd0;
      for (int i = 0; i < 7; i++) begin
         clk_step();
         n_chk++; if (bus.o_led !== 4'h1 || bus.o_tick !== 1'b0)
            $display("FAIL spd_pre i=%0d got=%h/%b exp=1/0", i, bus.o_led, bus.o_tick); else n_pass++;
      end
      bus.i_speed = 2'd0;
      clk_step();
      n_chk++; if (bus.o_led !== 4'h2 || bus.o_tick !== 1'b1)
         $display("FAIL spd_wrap got=%h/%b exp=2/1", bus.o_led, bus.o_tick); else n_pass++;
      bus.i_enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         clk_step();
         n_chk++; if (bus.o_led !== 4'h2 || bus.o_tick !== 1'b0)
            $display("FAIL hold i=%0d got=%h/%b exp=2/0", i, bus.o_led, bus.o_tick); else n_pass++;
      end
   endtask

   task automatic test_mode_on_wrap();
      bus.i_enable = 1'b1; bus.i_speed = 2'd3;
      clk_step();
      n_chk++; if (bus.o_led !== 4'h4 || bus.o_tick !== 1'b1)
         $display("FAIL wrap_step got=%h/%b exp=4/1", bus.o_led, bus.o_tick); else n_pass++;
      bus.i_mode = 2'd1;
      clk_step();
      n_chk++; if (bus.o_led !== 4'h1 || bus.o_tick !== 1'b0)
         $display("FAIL chg_on_wrap got=%h/%b exp=1/0", bus.o_led, bus.o_tick); else n_pass++;
      clk_step();
      n_chk++; if (bus.o_led !== 4'h8 || bus.o_tick !== 1'b1)
         $display("FAIL rotr_step got=%h/%b exp=8/1", bus.o_led, bus.o_tick); else n_pass++;
      #2 i_reset = 1'b0;
      model_reset();
      #1;
      n_chk++; if (bus.o_led !== 4'h1 || bus.o_tick !== 1'b0)
         $display("FAIL async_rst got=%h/%b exp=1/0", bus.o_led, bus.o_tick); else n_pass++;
      repeat (2) clk_step();
      i_reset = 1'b1;
      clk_step();
      n_chk++; if (bus.o_led !== 4'h1 || bus.o_tick !== 1'b0)
         $display("FAIL post_rst_reload got=%h/%b exp=1/0", bus.o_led, bus.o_tick); else n_pass++;
      clk_step();
      n_chk++; if (bus.o_led !== 4'h8 || bus.o_tick !== 1'b1)
         $display("FAIL post_rst_step got=%h/%b exp=8/1", bus.o_led, bus.o_tick); else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         bus.i_enable = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 19) == 0) bus.i_mode  = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0)  bus.i_speed = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0)  bus.i_color = 2'($urandom_range(0, 3));
         clk_step();
         n_chk++; if (bus.o_led !== exp_led()) $display("FAIL rnd_led i=%0d got=%h exp=%h", i, bus.o_led, exp_led()); else n_pass++;
         n_chk++; if (bus.o_tick !== m_tick) $display("FAIL rnd_tick i=%0d got=%b exp=%b", i, bus.o_tick, m_tick); else n_pass++;
         n_chk++; if (bus.o_led_r !== exp_col(0)) $display("FAIL rnd_r i=%0d got=%h exp=%h", i, bus.o_led_r, exp_col(0)); else n_pass++;
         n_chk++; if (bus.o_led_g !== exp_col(1)) $display("FAIL rnd_g i=%0d got=%h exp=%h", i, bus.o_led_g, exp_col(1)); else n_pass++;
         n_chk++; if (bus.o_led_b !== exp_col(2)) $display("FAIL rnd_b i=%0d got=%h exp=%h", i, bus.o_led_b, exp_col(2)); else n_pass++;
      end
   endtask

   task automatic test_pwm();
      int         on_cnt;
      int         exp_on;
      logic [3:0] led0;
      logic       steady;
      bus.i_mode = 2'd0; bus.i_enable = 1'b0; bus.i_color = 2'd0;
      clk_step();
      led0 = bus.o_led; on_cnt = 0; steady = 1'b1;
`ifdef LED_SEQ_PWM_EN
      exp_on = 64;
`else
      exp_on = 256;
`endif
      for (int i = 0; i < 256; i++) begin
         clk_step();
         if (bus.o_led_r != 4'h0) on_cnt++;
         if (bus.o_led !== led0) steady = 1'b0;
      end
      n_chk++; if (on_cnt != exp_on) $display("FAIL pwm_on got=%0d exp=%0d", on_cnt, exp_on); else n_pass++;
      n_chk++; if (steady !== 1'b1 || led0 === 4'h0) $display("FAIL pwm_led_steady got=%b led=%h", steady, led0); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_rot_left();
      test_pingpong();
      test_flash();
      test_speed_hold();
      test_mode_on_wrap();
      test_random();
      test_pwm();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
